// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-4 Booth multiplier.
// Consumed by booth_r4_recoder and booth_radix4_multiplier.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

    typedef enum logic [2:0] {
        ZERO,
        PM,
        P2M,
        M2M,
        MM
    } digit_e;

    // Two multiplier bits retire per iteration over the extended width.
    function automatic int booth_iters(input int width);
        return (width + 2) / 2;
    endfunction

endpackage

// File: rtl/booth_r4_recoder.sv
// Radix-4 Booth digit recoder: triple -> partial product.
// Purely combinational; result is sign-extended to EW+2 bits.
module booth_r4_recoder
    import booth_pkg::*;
#(
    parameter int EW = 18
) (
    input  logic [2:0]    i_triple,
    input  logic [EW-1:0] i_m_ext,
    output logic [EW+1:0] o_pp
);

    digit_e        w_digit;
    logic [EW+1:0] w_m;

    assign w_m = {{2{i_m_ext[EW-1]}}, i_m_ext};

    always_comb begin
        w_digit = ZERO;
        unique case (i_triple)
            3'b001, 3'b010: w_digit = PM;
            3'b011:         w_digit = P2M;
            3'b100:         w_digit = M2M;
            3'b101, 3'b110: w_digit = MM;
            default:        w_digit = ZERO;
        endcase
    end

    always_comb begin
        o_pp = '0;
        unique case (w_digit)
            PM:      o_pp = w_m;
            P2M:     o_pp = w_m << 1;
            M2M:     o_pp = -(w_m << 1);
            MM:      o_pp = -w_m;
            default: o_pp = '0;
        endcase
    end

endmodule

// File: rtl/booth_radix4_multiplier.sv
// Iterative radix-4 Booth multiplier, start/busy/done handshake.
// Define BOOTH_UNSIGNED_EN to add the is_signed port (unsigned mode).
module booth_radix4_multiplier
    import booth_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
`ifdef BOOTH_UNSIGNED_EN
    input  logic               is_signed,
`endif
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int EW = WIDTH + 2;
    localparam int N  = booth_iters(WIDTH);
    localparam int CW = $clog2(N + 1);

    state_e              r_state;
    state_e              w_next;
    logic [EW+1:0]       r_acc;
    logic [EW-1:0]       r_q;
    logic [EW-1:0]       r_m;
    logic                r_qm1;
    logic [CW-1:0]       r_cnt;
    logic                r_busy;
    logic                r_done;
    logic [2*WIDTH-1:0]  r_product;

    logic                w_sext;
    logic [EW-1:0]       w_m_ext;
    logic [EW-1:0]       w_q_ext;
    logic [EW+1:0]       w_pp;
    logic [EW+1:0]       w_sum;
    logic [2*EW+1:0]     w_full;
    logic                w_unused;

`ifdef BOOTH_UNSIGNED_EN
    assign w_sext = is_signed;
`else
    assign w_sext = 1'b1;
`endif

    assign w_m_ext = {{2{w_sext & multiplicand[WIDTH-1]}}, multiplicand};
    assign w_q_ext = {{2{w_sext & multiplier[WIDTH-1]}}, multiplier};

    booth_r4_recoder #(
        .EW(EW)
    ) u_recoder (
        .i_triple (  {r_q[1:0], r_qm1}),
        .i_m_ext  (  r_m),
        .o_pp     (  w_pp)
    );

    assign w_sum    = r_acc + w_pp;
    assign w_full   = {r_acc, r_q};
    assign w_unused = ^w_full[2*EW+1:2*WIDTH];

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: if (start) w_next = CALC;
            CALC: if (r_cnt == CW'(1)) w_next = DONE;
            DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc     <= '0;
            r_q       <= '0;
            r_m       <= '0;
            r_qm1     <= 1'b0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_product <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_m    <= w_m_ext;
                        r_q    <= w_q_ext;
                        r_acc  <= '0;
                        r_qm1  <= 1'b0;
                        r_cnt  <= CW'(N);
                        r_busy <= 1'b1;
                    end
                end
                CALC: begin
                    // Add digit, then arithmetic shift {A,Q,q-1} right by two.
                    r_acc <= {{2{w_sum[EW+1]}}, w_sum[EW+1:2]};
                    r_q   <= {w_sum[1:0], r_q[EW-1:2]};
                    r_qm1 <= r_q[1];
                    r_cnt <= r_cnt - CW'(1);
                end
                DONE: begin
                    r_product <= w_full[2*WIDTH-1:0];
                    r_done    <= 1'b1;
                    r_busy    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign product = r_product;

endmodule

// File: tb/tb_booth_radix4_multiplier.sv
// Self-checking bench: WIDTH=16 and WIDTH=8 instances
// against an arithmetic reference model.
module tb_booth_radix4_multiplier;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start16 = 1'b0;
    logic [15:0] a16 = '0;
    logic [15:0] b16 = '0;
    logic        sg16 = 1'b1;
    logic        busy16;
    logic        done16;
    logic [31:0] prod16;

    logic        start8 = 1'b0;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        sg8 = 1'b1;
    logic        busy8;
    logic        done8;
    logic [15:0] prod8;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    booth_radix4_multiplier #(.WIDTH(16)) u_dut16 (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start16),
        .multiplicand (a16),
        .multiplier   (b16),
`ifdef BOOTH_UNSIGNED_EN
        .is_signed    (sg16),
`endif
        .busy         (busy16),
        .done         (done16),
        .product      (prod16)
    );

    booth_radix4_multiplier #(.WIDTH(8)) u_dut8 (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start8),
        .multiplicand (a8),
        .multiplier   (b8),
`ifdef BOOTH_UNSIGNED_EN
        .is_signed    (sg8),
`endif
        .busy         (busy8),
        .done         (done8),
        .product      (prod8)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref16(input logic [15:0] a,
                                          input logic [15:0] b,
                                          input bit sgn);
        longint x;
        longint y;
        longint r;
        x = sgn ? longint'($signed(a)) : longint'({48'd0, a});
        y = sgn ? longint'($signed(b)) : longint'({48'd0, b});
        r = x * y;
        return r[31:0];
    endfunction

    function automatic logic [15:0] ref8(input logic [7:0] a,
                                         input logic [7:0] b,
                                         input bit sgn);
        longint x;
        longint y;
        longint r;
        x = sgn ? longint'($signed(a)) : longint'({56'd0, a});
        y = sgn ? longint'($signed(b)) : longint'({56'd0, b});
        r = x * y;
        return r[15:0];
    endfunction

    // Drive a request so it is accepted on the next rising edge,
    // then count edges until done is seen.
    task automatic mul16(input logic [15:0] a, input logic [15:0] b,
                         input bit sgn, output logic [31:0] p,
                         output int lat);
        @(negedge clk);
        start16 = 1'b1;
        a16 = a;
        b16 = b;
        sg16 = sgn;
        @(posedge clk);
        #1;
        start16 = 1'b0;
        a16 = $urandom;
        b16 = $urandom;
        lat = 0;
        while (!done16 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        p = prod16;
    endtask

    task automatic mul8(input logic [7:0] a, input logic [7:0] b,
                        input bit sgn, output logic [15:0] p,
                        output int lat);
        @(negedge clk);
        start8 = 1'b1;
        a8 = a;
        b8 = b;
        sg8 = sgn;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        a8 = $urandom;
        b8 = $urandom;
        lat = 0;
        while (!done8 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        p = prod8;
    endtask

    initial begin
        logic [31:0] p16;
        logic [15:0] p8;
        logic [15:0] ra;
        logic [15:0] rb;
        logic [7:0]  sa;
        logic [7:0]  sb;
        bit          sg;
        int          lat;
        int          seen;

        // Reset wins over a simultaneous start.
        start16 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 64'(busy16), 64'(0));
        chk("reset_done", 64'(done16), 64'(0));
        chk("reset_product", 64'(prod16), 64'(0));
        chk("reset_busy8", 64'(busy8), 64'(0));
        start16 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        mul16(16'h0003, 16'hFFFB, 1'b1, p16, lat);
        chk("3xm5_prod", 64'(p16), 64'hFFFFFFF1);
        chk("3xm5_lat", 64'(lat), 64'(10));
        chk("3xm5_done_busy", 64'(busy16), 64'(0));
        @(posedge clk);
        #1;
        chk("done_pulse", 64'(done16), 64'(0));
        chk("busy_after_done", 64'(busy16), 64'(0));
        chk("product_held", 64'(prod16), 64'hFFFFFFF1);

        mul16(16'h8000, 16'h8000, 1'b1, p16, lat);
        chk("min_sq", 64'(p16), 64'h40000000);
        mul16(16'h7FFF, 16'h8000, 1'b1, p16, lat);
        chk("max_x_min", 64'(p16), 64'hC0008000);

`ifdef BOOTH_UNSIGNED_EN
        mul16(16'hFFFF, 16'hFFFF, 1'b0, p16, lat);
        chk("uns_ffff", 64'(p16), 64'hFFFE0001);
        chk("uns_lat", 64'(lat), 64'(10));
        mul16(16'hFFFF, 16'hFFFF, 1'b1, p16, lat);
        chk("sgn_ffff", 64'(p16), 64'h00000001);
`endif

        // Starts during CALC must be ignored.
        @(negedge clk);
        start16 = 1'b1;
        a16 = 16'd1234;
        b16 = 16'hFF85;
        sg16 = 1'b1;
        @(posedge clk);
        #1;
        start16 = 1'b0;
        lat = 0;
        while (!done16 && lat < 40) begin
            start16 = (lat == 2 || lat == 5);
            a16 = 16'h0101;
            b16 = 16'h0202;
            @(posedge clk);
            #1;
            lat++;
        end
        start16 = 1'b0;
        chk("ignore_prod", 64'(prod16), 64'(ref16(16'd1234, 16'hFF85, 1'b1)));
        chk("ignore_lat", 64'(lat), 64'(10));
        mul16(16'h0101, 16'h0202, 1'b1, p16, lat);
        chk("back2back_prod", 64'(p16), 64'h00020402);
        chk("back2back_lat", 64'(lat), 64'(10));

        // Reset during CALC abandons the operation.
        @(negedge clk);
        start16 = 1'b1;
        a16 = 16'd77;
        b16 = 16'd55;
        @(posedge clk);
        #1;
        start16 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_busy", 64'(busy16), 64'(0));
        chk("midrst_done", 64'(done16), 64'(0));
        chk("midrst_product", 64'(prod16), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done16 || busy16) seen++;
        end
        chk("midrst_no_done", 64'(seen), 64'(0));
        mul16(16'd77, 16'd55, 1'b1, p16, lat);
        chk("post_rst_prod", 64'(p16), 64'(4235));
        chk("post_rst_lat", 64'(lat), 64'(10));

        mul8(8'h80, 8'h7F, 1'b1, p8, lat);
        chk("w8_prod", 64'(p8), 64'hC080);
        chk("w8_lat", 64'(lat), 64'(6));
        mul8(8'h80, 8'h80, 1'b1, p8, lat);
        chk("w8_min_sq", 64'(p8), 64'h4000);

        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            sg = 1'b1;
`ifdef BOOTH_UNSIGNED_EN
            sg = 1'($urandom_range(0, 1));
`endif
            mul16(ra, rb, sg, p16, lat);
            chk("rand16", 64'(p16), 64'(ref16(ra, rb, sg)));
            if (lat != 10) chk("rand16_lat", 64'(lat), 64'(10));
        end

        for (int i = 0; i < 30; i++) begin
            sa = 8'($urandom);
            sb = 8'($urandom);
            sg = 1'b1;
`ifdef BOOTH_UNSIGNED_EN
            sg = 1'($urandom_range(0, 1));
`endif
            mul8(sa, sb, sg, p8, lat);
            chk("rand8", 64'(p8), 64'(ref8(sa, sb, sg)));
            if (lat != 6) chk("rand8_lat", 64'(lat), 64'(6));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
